width_downconv: RTL

Parametrised store-and-drain width down-converter for the UDP offload datapath. It accepts IN_W-bit words on a valid/ready stream and emits them as R = IN_W/OUT_W consecutive OUT_W-bit lanes, least-significant lane first. It carries packet framing through the conversion: last and byte-empty are honoured, so a short final word emits only the lanes that hold valid bytes. It sits between wide packet buffers and narrower MAC/checksum stages, and keeps full output throughput under back-pressure.

---
 rtl/width_downconv.sv | 124 ++++++++++++
 1 files changed

// File: rtl/width_downconv.sv
// width_downconv: store-and-drain width down-converter.
//
// Accepts IN_W-bit words on a valid/ready stream and emits each one as up to
// R = IN_W/OUT_W OUT_W-bit lanes, least-significant lane first. Packet framing
// is carried through: a final word with in_empty unused high bytes only emits
// the lanes that hold valid bytes, and the last lane reports its own empty count.
//
// Optional feature macro: WIDTH_DOWNCONV_BYTE_SWAP_EN
//   defined   - each output lane is byte-reversed (lane byte 0 on the top byte).
//   undefined - lanes pass through unmodified.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake
//   in_data [IN_W]         input word, byte 0 = bits [7:0]
//   in_last, in_empty      packet end flag, unused high bytes (only with in_last)
//   out_valid/out_ready    output handshake
//   out_data [OUT_W]       output lane
//   out_last, out_empty    final lane of packet, unused high bytes in that lane
//   busy                   holding register occupied (same as out_valid)
module width_downconv #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 32,
  localparam int unsigned IEW  = $clog2(IN_W / 8),
  localparam int unsigned OEW  = ((OUT_W / 8) > 1) ? $clog2(OUT_W / 8) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic [IEW-1:0]   in_empty,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [OEW-1:0]   out_empty,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned NB = IN_W / 8;
  localparam int unsigned B  = OUT_W / 8;
  localparam int unsigned R  = IN_W / OUT_W;
  localparam int unsigned LW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned VW = $clog2(NB + 1);

  // Holding register. The lane count is stored as the index of the final lane.
  logic             r_full;
  logic [IN_W-1:0]  r_data;
  logic             r_last;
  logic [LW-1:0]    r_lane_idx;
  logic [LW-1:0]    r_last_idx;
  logic [OEW-1:0]   r_last_empty;

  logic [VW-1:0]    w_v;
  logic [VW-1:0]    w_vm1;
  logic [LW-1:0]    w_last_idx;
  logic [OEW-1:0]   w_last_empty;
  logic             w_on_final;
  logic             w_accept;
  logic             w_consume;
  logic [OUT_W-1:0] w_lane;

  // Framing of the incoming word. B is a power of two, so the divide and
  // modulo reduce to wiring: last_idx = (V-1)/B, last_empty = B-1 - (V-1)%B.
  always_comb begin
    w_v          = VW'(NB) - (in_last ? VW'(in_empty) : VW'(0));
    w_vm1        = w_v - VW'(1);
    w_last_idx   = LW'(w_vm1 / VW'(B));
    w_last_empty = OEW'(VW'(B - 1) - (w_vm1 % VW'(B)));
  end

  assign w_on_final = (r_lane_idx == r_last_idx);
  assign w_consume  = r_full & out_ready;

  // Combinational from out_ready so a new word loads on the final-lane edge.
  assign in_ready = !rst & (!r_full | (out_ready & w_on_final));
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full       <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_lane_idx   <= '0;
      r_last_idx   <= '0;
      r_last_empty <= '0;
    end else if (w_accept) begin
      r_full       <= 1'b1;
      r_data       <= in_data;
      r_last       <= in_last;
      r_lane_idx   <= '0;
      r_last_idx   <= w_last_idx;
      r_last_empty <= w_last_empty;
    end else if (w_consume) begin
      if (w_on_final) begin
        r_full     <= 1'b0;
        r_lane_idx <= '0;
      end else begin
        r_lane_idx <= r_lane_idx + LW'(1);
      end
    end
  end

  assign w_lane = r_data[r_lane_idx * OUT_W +: OUT_W];

`ifdef WIDTH_DOWNCONV_BYTE_SWAP_EN
  always_comb begin
    out_data = '0;
    for (int i = 0; i < int'(B); i++) begin
      out_data[8*i +: 8] = w_lane[OUT_W - 8 - 8*i +: 8];
    end
  end
`else
  assign out_data = w_lane;
`endif

  assign out_valid = r_full;
  assign busy      = r_full;
  assign out_last  = r_full & r_last & w_on_final;
  assign out_empty = out_last ? r_last_empty : '0;

endmodule
